// File: rtl/dpd_train_ctrl.sv
// DPD training sequencer: fires the test-signal generator, opens a capture window aligned to the
// PA feedback path, then hands off to the coefficient estimator, repeating for cfg_iter passes.
module dpd_train_ctrl #(
    parameter int SIG_LEN = 1024,
    parameter int PB_LAT  = 4,
    parameter int DLY_W   = 8,
    parameter int TO_W    = 16,
    localparam int IDX_W  = $clog2(SIG_LEN)
) (
    input  logic             clk,
    input  logic             reset_b,
    input  logic             train_go,
    input  logic             train_abort,
    input  logic [3:0]       cfg_iter,
    input  logic [DLY_W-1:0] cfg_loop_dly,
    input  logic [TO_W-1:0]  cfg_timeout,
    output logic             tsig_start,
    output logic             cap_en,
    output logic [IDX_W-1:0] cap_idx,
    output logic             est_req,
    input  logic             est_ack,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [3:0]       iter_cnt
);

    typedef enum logic [2:0] {IDLE, START, WAIT, CAPT, EST} state_t;

    localparam logic [DLY_W+1:0] PB_LAT_M1 = (DLY_W+2)'(PB_LAT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(SIG_LEN - 1);

    state_t           state, state_nxt;
    logic             go_q;
    logic [DLY_W+1:0] tcnt;
    logic [DLY_W-1:0] loop_dly_q;
    logic [IDX_W-1:0] idx;
    logic [TO_W-1:0]  to_cnt;
    logic [3:0]       iter_tgt;
    logic [3:0]       iter_cnt_q;
    logic             err_q;
    logic             done_q;

    logic       go_rise;
    logic       abort;
    logic       cap_hit;
    logic       timeout_hit;
    logic [3:0] iter_inc;
    logic       last_iter;

    assign go_rise     = train_go & ~go_q;
    assign abort       = train_abort && (state != IDLE);
    assign cap_hit     = (tcnt == PB_LAT_M1 + {2'b00, loop_dly_q});
    assign timeout_hit = (cfg_timeout != '0) && ((to_cnt + TO_W'(1)) == cfg_timeout);
    assign iter_inc    = (iter_cnt_q == 4'hF) ? 4'hF : iter_cnt_q + 4'd1;
    assign last_iter   = (iter_inc == iter_tgt);

    // tcnt counts cycles since T0, so the WAIT exit lands cap_en on T0+PB_LAT+loop_dly
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (go_rise) state_nxt = START;
            START: if (tcnt == (DLY_W+2)'(1)) state_nxt = WAIT;
            WAIT:  if (cap_hit) state_nxt = CAPT;
            CAPT:  if (idx == IDX_LAST) state_nxt = EST;
            EST: begin
                if (est_ack)          state_nxt = last_iter ? IDLE : START;
                else if (timeout_hit) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (abort) state_nxt = IDLE;
    end

    // go_q resets high so a go held through reset release is not taken as a new edge
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state      <= IDLE;
            go_q       <= 1'b1;
            tcnt       <= '0;
            loop_dly_q <= '0;
            idx        <= '0;
            to_cnt     <= '0;
            iter_tgt   <= 4'd1;
            iter_cnt_q <= '0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state  <= state_nxt;
            go_q   <= train_go;
            tcnt   <= (state == START || state == WAIT) ? tcnt + 1'b1 : '0;
            idx    <= (state == CAPT && state_nxt == CAPT) ? idx + 1'b1 : '0;
            to_cnt <= (state == EST && state_nxt == EST) ? to_cnt + 1'b1 : '0;
            done_q <= 1'b0;
            if (state == START && tcnt == '0)
                loop_dly_q <= cfg_loop_dly;
            if (state == IDLE && go_rise) begin
                err_q      <= 1'b0;
                iter_cnt_q <= '0;
                iter_tgt   <= (cfg_iter == 4'd0) ? 4'd1 : cfg_iter;
            end else if (abort) begin
                err_q <= 1'b1;
            end else if (state == EST) begin
                if (est_ack) begin
                    iter_cnt_q <= iter_inc;
                    if (last_iter) done_q <= 1'b1;
                end else if (timeout_hit) begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    assign tsig_start = (state == START);
    assign cap_en     = (state == CAPT);
    assign cap_idx    = idx;
    assign est_req    = (state == EST);
    assign busy       = (state != IDLE);
    assign done       = done_q;
    assign err        = err_q;
    assign iter_cnt   = iter_cnt_q;

endmodule

// File: tb/tb_dpd_train_ctrl.sv
// Directed bench for dpd_train_ctrl: single/multi iteration runs, timeout, abort, ack-vs-timeout
// race, and async reset with go held high.
module tb_dpd_train_ctrl;

    logic        clk = 1'b0;
    logic        reset_b;
    logic        train_go;
    logic        train_abort;
    logic [3:0]  cfg_iter;
    logic [7:0]  cfg_loop_dly;
    logic [15:0] cfg_timeout;
    logic        tsig_start;
    logic        cap_en;
    logic [9:0]  cap_idx;
    logic        est_req;
    logic        est_ack;
    logic        busy;
    logic        done;
    logic        err;
    logic [3:0]  iter_cnt;

    int checks = 0;
    int errors = 0;

    dpd_train_ctrl dut (
        .clk          (clk),
        .reset_b      (reset_b),
        .train_go     (train_go),
        .train_abort  (train_abort),
        .cfg_iter     (cfg_iter),
        .cfg_loop_dly (cfg_loop_dly),
        .cfg_timeout  (cfg_timeout),
        .tsig_start   (tsig_start),
        .cap_en       (cap_en),
        .cap_idx      (cap_idx),
        .est_req      (est_req),
        .est_ack      (est_ack),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .iter_cnt     (iter_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic step_clock();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic go, input logic abort_in, input logic ack);
        train_go    = go;
        train_abort = abort_in;
        est_ack     = ack;
        step_clock();
    endtask

    // Entered at T0 (first START cycle); leaves in EST cycle 1+hold with est_ack low
    task automatic run_window(input int dly, input string tag, input int hold);
        int k;
        int n;
        int bad;
        est_ack = 1'b0;
        check_output({tag, "_tsig_t0"}, int'(tsig_start), 1);
        step_clock();
        check_output({tag, "_tsig_t1"}, int'(tsig_start), 1);
        step_clock();
        check_output({tag, "_tsig_t2"}, int'(tsig_start), 0);
        k = 2;
        while (!cap_en && k < 2000) begin
            step_clock();
            k++;
        end
        check_output({tag, "_cap_rise"}, k, 4 + dly);
        n   = 0;
        bad = 0;
        while (cap_en && n < 2000) begin
            if (int'(cap_idx) != n) bad++;
            step_clock();
            n++;
        end
        check_output({tag, "_cap_len"}, n, 1024);
        check_output({tag, "_idx_seq"}, bad, 0);
        check_output({tag, "_est_req"}, int'(est_req), 1);
        for (int i = 0; i < hold; i++) step_clock();
        if (hold > 0) check_output({tag, "_est_hold"}, int'(est_req), 1);
    endtask

    initial begin
        int n;
        reset_b      = 1'b0;
        train_go     = 1'b0;
        train_abort  = 1'b0;
        est_ack      = 1'b0;
        cfg_iter     = 4'd1;
        cfg_loop_dly = 8'd0;
        cfg_timeout  = 16'd0;
        repeat (3) @(posedge clk);
        #1;
        check_output("rst_busy", int'(busy), 0);
        check_output("rst_outs", int'({tsig_start, cap_en, est_req, done, err}), 0);
        check_output("rst_iter", int'(iter_cnt), 0);
        reset_b = 1'b1;
        step_clock();
        check_output("idle_busy", int'(busy), 0);

        // 1) single iteration, no loop delay; go stays high the whole run
        apply_stimulus(1'b1, 1'b0, 1'b0);
        check_output("t1_busy", int'(busy), 1);
        run_window(0, "t1", 3);
        apply_stimulus(1'b1, 1'b0, 1'b1);
        check_output("t1_done", int'(done), 1);
        check_output("t1_iter", int'(iter_cnt), 1);
        check_output("t1_idle", int'(busy), 0);
        step_clock();
        check_output("t1_done_pulse", int'(done), 0);
        repeat (3) step_clock();
        check_output("t1_no_retrig", int'(busy), 0);

        // 2) three iterations with 20-cycle loop delay
        cfg_iter     = 4'd3;
        cfg_loop_dly = 8'd20;
        apply_stimulus(1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            run_window(20, $sformatf("t2_i%0d", i), 2);
            apply_stimulus(1'b0, 1'b0, 1'b1);
            check_output($sformatf("t2_iter%0d", i), int'(iter_cnt), i);
            check_output($sformatf("t2_done%0d", i), int'(done), (i == 3) ? 1 : 0);
            check_output($sformatf("t2_busy%0d", i), int'(busy), (i == 3) ? 0 : 1);
        end

        // 3) estimator timeout after 100 EST cycles
        cfg_iter     = 4'd1;
        cfg_loop_dly = 8'd0;
        cfg_timeout  = 16'd100;
        apply_stimulus(1'b1, 1'b0, 1'b0);
        run_window(0, "t3", 0);
        n = 0;
        while (est_req && n < 500) begin
            n++;
            step_clock();
        end
        check_output("t3_est_cycles", n, 100);
        check_output("t3_err", int'(err), 1);
        check_output("t3_no_done", int'(done), 0);
        check_output("t3_idle", int'(busy), 0);
        check_output("t3_iter", int'(iter_cnt), 0);

        // 4) abort in second iteration at cap_idx 500; go clears err first
        cfg_iter     = 4'd2;
        cfg_timeout  = 16'd0;
        cfg_loop_dly = 8'd5;
        apply_stimulus(1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b0, 1'b0);
        check_output("t4_err_clr", int'(err), 0);
        run_window(5, "t4", 1);
        apply_stimulus(1'b0, 1'b0, 1'b1);
        check_output("t4_iter1", int'(iter_cnt), 1);
        n = 0;
        while (!(cap_en && cap_idx == 10'd500) && n < 2000) begin
            step_clock();
            n++;
        end
        check_output("t4_reach500", n, 5 + 4 + 500);
        apply_stimulus(1'b0, 1'b1, 1'b0);
        check_output("t4_cap_off", int'(cap_en), 0);
        check_output("t4_idle", int'(busy), 0);
        check_output("t4_err", int'(err), 1);
        check_output("t4_iter_held", int'(iter_cnt), 1);
        check_output("t4_no_done", int'(done), 0);
        apply_stimulus(1'b0, 1'b0, 1'b1);
        check_output("t4_ack_idle", int'(iter_cnt), 1);

        // 6) async reset mid-WAIT with go held high through release
        cfg_loop_dly = 8'd0;
        apply_stimulus(1'b1, 1'b0, 1'b0);
        run_window(0, "t6", 1);
        apply_stimulus(1'b0, 1'b0, 1'b1);
        check_output("t6_iter1", int'(iter_cnt), 1);
        repeat (3) step_clock();
        check_output("t6_in_wait", int'({busy, cap_en, tsig_start}), 4);
        reset_b  = 1'b0;
        train_go = 1'b1;
        #1;
        check_output("t6_async_busy", int'(busy), 0);
        check_output("t6_async_iter", int'(iter_cnt), 0);
        check_output("t6_async_outs", int'({tsig_start, cap_en, est_req, done, err}), 0);
        repeat (2) @(posedge clk);
        #1;
        reset_b = 1'b1;
        repeat (5) step_clock();
        check_output("t6_go_held", int'(busy), 0);
        apply_stimulus(1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b0, 1'b0);
        check_output("t6_restart", int'(tsig_start), 1);
        apply_stimulus(1'b0, 1'b1, 1'b0);
        check_output("t6_abort_idle", int'(busy), 0);

        // 5) ack on the timeout cycle wins; cfg_iter 0 runs one pass
        cfg_iter    = 4'd0;
        cfg_timeout = 16'd10;
        apply_stimulus(1'b1, 1'b0, 1'b0);
        check_output("t5_err_clr", int'(err), 0);
        run_window(0, "t5", 9);
        apply_stimulus(1'b0, 1'b0, 1'b1);
        check_output("t5_done", int'(done), 1);
        check_output("t5_err", int'(err), 0);
        check_output("t5_iter", int'(iter_cnt), 1);
        check_output("t5_idle", int'(busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
